// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO with first-word-fall-through registered output.
// Define UART_RX_FIFO_DROP_EN for a never-stall input that drops bytes on overflow.
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = 12,
   localparam int LB_DEPTH  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [LB_DEPTH:0]     level,
   output logic                  almost_full,
   output logic                  overflow
);

   localparam logic [LB_DEPTH:0] PTR_ONE = (LB_DEPTH+1)'(1);
   localparam logic [LB_DEPTH:0] AF_LVL  = (LB_DEPTH+1)'(AF_THRESH);

   // The memory holds every entry, including a copy of the head byte that
   // also sits in the output register.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [LB_DEPTH:0]     wr_ptr_q, wr_ptr_d;
   logic [LB_DEPTH:0]     rd_ptr_q, rd_ptr_d;
   logic [LB_DEPTH:0]     level_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  m_valid_q, m_valid_d;
   logic                  af_q, af_d;
   logic                  full, empty, push, pop;

   assign level = wr_ptr_q - rd_ptr_q;
   assign full  = (wr_ptr_q[LB_DEPTH] != rd_ptr_q[LB_DEPTH]) &&
                  (wr_ptr_q[LB_DEPTH-1:0] == rd_ptr_q[LB_DEPTH-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign pop   = m_valid_q && m_ready && !clear;

`ifdef UART_RX_FIFO_DROP_EN
   logic ovf_q, ovf_d;
   logic drop;

   assign s_ready = 1'b1;
   assign push    = s_valid && !clear && (!full || pop);
   assign drop    = s_valid && !clear && full && !pop;

   always_comb begin
      ovf_d = ovf_q;
      if (clear) begin
         ovf_d = 1'b0;
      end else if (drop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow = ovf_q;
`else
   assign s_ready  = !full;
   assign push     = s_valid && !full && !clear;
   assign overflow = 1'b0;
`endif

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      if (clear) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         m_valid_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         // Head reload: next stored byte, or the incoming byte when it is the only one left.
         if (pop) begin
            if (level > PTR_ONE) begin
               m_data_d = mem_q[rd_ptr_d[LB_DEPTH-1:0]];
            end else if (push) begin
               m_data_d = s_data;
            end
         end else if (push && empty) begin
            m_data_d = s_data;
         end
         m_valid_d = (wr_ptr_d != rd_ptr_d);
      end
      level_d = wr_ptr_d - rd_ptr_d;
      af_d    = (level_d >= AF_LVL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         af_q      <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         af_q      <= af_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[LB_DEPTH-1:0]] <= s_data;
      end
   end

   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign almost_full = af_q;

endmodule
